// File: rtl/spi_master.sv
// spi_master: host-side valid/ready command port to a single-clock SPI slave.
// One MOSI/MISO bit moves per clk cycle. A frame is a leading command bit
// (cmd_data[9]) followed by the 10 command bits LSB first. Read-data commands
// (opcode 2'b11) then wait RD_WAIT cycles and shift in 8 MISO bits, MSB first.
//
// Ports:
//   clk, rst           system clock (rising edge), synchronous active-high reset
//   cmd_valid/ready    host command handshake; ready only while idle
//   cmd_data[9:0]      [9:8] opcode, [7:0] payload
//   abort              ends the current frame early (ignored when idle/ending)
//   MISO               serial data from slave, sampled only while receiving
//   SS_n, MOSI         registered slave select / serial data to slave
//   rd_data, rd_valid  received byte and its one-cycle update strobe
//   busy               high whenever not idle
module spi_master #(
  parameter int RD_WAIT = 3,
  parameter int GAP     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [9:0] cmd_data,
  input  logic       abort,
  input  logic       MISO,
  output logic       SS_n,
  output logic       MOSI,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_SHIFT, S_WAIT, S_RECV, S_END
  } state_t;

  localparam logic [3:0] WAIT_LAST = (RD_WAIT > 0) ? 4'(RD_WAIT - 1) : 4'd0;
  localparam logic [3:0] GAP_LAST  = 4'(GAP - 1);

  state_t     r_state, w_next;
  logic [3:0] r_cnt;
  logic [9:0] r_tx;
  logic [7:0] r_rx;
  logic       r_ss_n, r_mosi, r_rd_valid;
  logic [7:0] r_rd_data;
  logic       w_active, w_abort, w_mosi;

  always_comb begin
    w_next   = r_state;
    w_mosi   = 1'b0;
    w_active = 1'b0;
    case (r_state)
      S_IDLE:  if (cmd_valid) w_next = S_START;
      S_START: begin
        w_active = 1'b1;
        w_mosi   = r_tx[9];
        w_next   = S_SHIFT;
      end
      S_SHIFT: begin
        w_active = 1'b1;
        w_mosi   = r_tx[r_cnt];
        if (r_cnt == 4'd9) begin
          if (r_tx[9:8] == 2'b11) w_next = (RD_WAIT == 0) ? S_RECV : S_WAIT;
          else                    w_next = S_END;
        end
      end
      S_WAIT: begin
        w_active = 1'b1;
        if (r_cnt == WAIT_LAST) w_next = S_RECV;
      end
      S_RECV: begin
        w_active = 1'b1;
        if (r_cnt == 4'd7) w_next = S_END;
      end
      S_END:   if (r_cnt == GAP_LAST) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    w_abort = w_active & abort;
    if (w_abort) w_next = S_END;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      // Counter restarts on every state change so each state times itself.
      r_cnt   <= (w_next != r_state) ? 4'd0 : r_cnt + 4'd1;
    end
  end

  // Serial outputs follow the state one cycle later; an abort forces the
  // line back to deselected on the very edge that samples it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ss_n     <= 1'b1;
      r_mosi     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= 8'h00;
      r_tx       <= '0;
      r_rx       <= '0;
    end else begin
      r_ss_n     <= ~w_active | w_abort;
      r_mosi     <= w_mosi & ~w_abort;
      r_rd_valid <= 1'b0;
      if (r_state == S_IDLE && cmd_valid) r_tx <= cmd_data;
      if (r_state == S_RECV && !w_abort) begin
        r_rx <= {r_rx[6:0], MISO};
        if (r_cnt == 4'd7) begin
          r_rd_data  <= {r_rx[6:0], MISO};
          r_rd_valid <= 1'b1;
        end
      end
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign SS_n      = r_ss_n;
  assign MOSI      = r_mosi;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;
  localparam int RD_WAIT = 3;
  localparam int GAP     = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [9:0] cmd_data = '0;
  logic       abort = 1'b0;
  logic       MISO = 1'b0;
  logic       cmd_ready, SS_n, MOSI, rd_valid, busy;
  logic [7:0] rd_data;

  int total = 0;
  int bad   = 0;

  spi_master #(.RD_WAIT(RD_WAIT), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .abort(abort), .MISO(MISO), .SS_n(SS_n),
    .MOSI(MOSI), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is described by edges counted from the accept
  // edge. L = last edge with SS_n low, A = edge entering the end gap.
  logic       m_ok = 1'b0;
  logic       m_busy = 1'b0, m_ab = 1'b0, m_rd = 1'b0;
  logic       m_ss = 1'b1, m_mosi = 1'b0, m_rdv = 1'b0;
  logic [9:0] mc = '0;
  logic [7:0] m_rx = '0, m_rdd = '0;
  int         t = 0, L = 0, A = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_ss = 1'b1; m_mosi = 1'b0; m_rdv = 1'b0; m_rdd = 8'h00;
      m_ok = 1'b1;
    end else begin
      m_rdv = 1'b0;
      if (!m_busy) begin
        m_ss = 1'b1; m_mosi = 1'b0;
        if (cmd_valid) begin
          m_busy = 1'b1; t = 0; mc = cmd_data; m_ab = 1'b0;
          m_rd = (cmd_data[9:8] == 2'b11);
          L = m_rd ? 19 + RD_WAIT : 11;
          A = L;
        end
      end else begin
        t++;
        if (!m_ab && t <= L) begin
          if (abort) begin
            m_ab = 1'b1; A = t; m_ss = 1'b1; m_mosi = 1'b0;
          end else begin
            m_ss = 1'b0;
            m_mosi = (t == 1) ? mc[9] : (t <= 11) ? mc[t-2] : 1'b0;
            if (m_rd && t >= L - 7) begin
              m_rx = {m_rx[6:0], MISO};
              if (t == L) begin m_rdd = m_rx; m_rdv = 1'b1; end
            end
          end
        end else begin
          m_ss = 1'b1; m_mosi = 1'b0;
        end
        if (t == A + GAP) m_busy = 1'b0;
      end
    end
  end

  int   falls = 0;
  logic prev_ss = 1'b1;
  always @(negedge clk) begin
    if (m_ok) begin
      chk("ss_n", 32'(SS_n), 32'(m_ss));
      chk("mosi", 32'(MOSI), 32'(m_mosi));
      chk("rd_valid", 32'(rd_valid), 32'(m_rdv));
      chk("rd_data", 32'(rd_data), 32'(m_rdd));
      chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
      chk("busy", 32'(busy), 32'(m_busy));
    end
    if (prev_ss && !SS_n) falls++;
    prev_ss = SS_n;
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      total++; bad++;
      $display("FAIL %s: cmd_ready timeout got 0 expected 1", name);
    end
  endtask

  // Issues one command from idle and steps to the first idle cycle after it.
  task automatic send(input logic [9:0] c, input logic [7:0] mb, input int ab_at,
                      input int pulse_at, output int ss_low, output int rdv_n,
                      output logic [10:0] mseq);
    int len, a;
    len = (c[9:8] == 2'b11) ? 19 + RD_WAIT : 11;
    a = (ab_at >= 1 && ab_at <= len) ? ab_at : len;
    ss_low = 0; rdv_n = 0; mseq = '0;
    cmd_valid = 1'b1; cmd_data = c;
    wait_ready("send_accept");
    @(negedge clk);
    cmd_valid = 1'b0; cmd_data = 10'($urandom);
    for (int k = 1; k <= a + GAP; k++) begin
      MISO = (k >= len - 7 && k <= len) ? mb[len-k] : 1'($urandom);
      abort = (k == ab_at);
      cmd_valid = (k == pulse_at);
      @(negedge clk);
      if (!SS_n) ss_low++;
      if (rd_valid) rdv_n++;
      if (k <= 11) mseq[k-1] = MOSI;
    end
    abort = 1'b0; cmd_valid = 1'b0;
  endtask

  initial begin
    int sl, rv, f0, len, a, ab, pu;
    logic [10:0] ms;
    logic [9:0]  c;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 32'(cmd_ready), 32'd1);
    chk("reset_ss", 32'(SS_n), 32'd1);

    // write address 0x0A5
    f0 = falls;
    send(10'h0A5, 8'h00, 0, 0, sl, rv, ms);
    chk("wr_mosi_seq", 32'(ms), 32'h14A);
    chk("wr_ss_low", 32'(sl), 32'd11);
    chk("wr_frames", 32'(falls - f0), 32'd1);

    // read data, MISO 1,0,1,1,0,0,1,0
    send(10'h300, 8'hB2, 0, 0, sl, rv, ms);
    chk("rd_byte", 32'(rd_data), 32'hB2);
    chk("rd_pulses", 32'(rv), 32'd1);
    chk("rd_ss_low", 32'(sl), 32'd22);

    // abort at SHIFT bit 4 (sampled on edge 6)
    send(10'h3FF, 8'h5A, 6, 0, sl, rv, ms);
    chk("ab_pulses", 32'(rv), 32'd0);
    chk("ab_rd_data", 32'(rd_data), 32'hB2);
    chk("ab_ss_low", 32'(sl), 32'd5);

    // reset while shifting
    cmd_valid = 1'b1; cmd_data = 10'h2C3;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ss", 32'(SS_n), 32'd1);
    chk("rst_mosi", 32'(MOSI), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'h00);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // back-to-back with cmd_valid held
    f0 = falls;
    cmd_valid = 1'b1; cmd_data = 10'h1C4;
    wait_ready("b2b_first");
    @(negedge clk);
    cmd_data = 10'h2E7;
    @(negedge clk);
    wait_ready("b2b_second");
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_ready("b2b_done");
    chk("b2b_frames", 32'(falls - f0), 32'd2);

    // one-cycle cmd_valid while busy is ignored
    f0 = falls;
    send(10'h155, 8'h00, 0, 4, sl, rv, ms);
    repeat (3) @(negedge clk);
    chk("busy_ignore_frames", 32'(falls - f0), 32'd1);

    // randomized commands, aborts and busy pulses
    for (int i = 0; i < 40; i++) begin
      c   = 10'($urandom);
      if (i % 3 == 0) c[9:8] = 2'b11;
      len = (c[9:8] == 2'b11) ? 19 + RD_WAIT : 11;
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, len + GAP)) : 0;
      a   = (ab >= 1 && ab <= len) ? ab : len;
      pu  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, a)) : 0;
      send(c, 8'($urandom), ab, pu, sl, rv, ms);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
